// File: rtl/switch_pkg.sv
// switch_pkg: shared ingress FSM encoding, one-hot tdest decode and VOQ entry layout helpers
package switch_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} ingress_state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] idx;
   } onehot_t;

   // valid only when exactly one bit is set; idx is then that bit's position
   function automatic onehot_t onehot_encode(input logic [31:0] v);
      onehot_t r;
      r.valid = (v != '0) && ((v & (v - 32'd1)) == '0);
      r.idx   = '0;
      for (int i = 0; i < 32; i++) if (v[i]) r.idx = 5'(i);
      return r;
   endfunction

   // Stored entry, LSB first: user, dest, id, last, keep, data
   function automatic int off_dest(input int uw);
      return uw;
   endfunction

   function automatic int off_id(input int uw, input int tw);
      return uw + tw;
   endfunction

   function automatic int off_last(input int uw, input int tw, input int iw);
      return uw + tw + iw;
   endfunction

   function automatic int off_keep(input int uw, input int tw, input int iw);
      return uw + tw + iw + 1;
   endfunction

   function automatic int off_data(input int uw, input int tw, input int iw, input int kw);
      return uw + tw + iw + 1 + kw;
   endfunction

   function automatic int entry_width(input int uw, input int tw, input int iw, input int kw, input int dw);
      return uw + tw + iw + 1 + kw + dw;
   endfunction

endpackage

// File: rtl/switch_voq_fifo.sv
// switch_voq_fifo: single-clock VOQ queue with AXIS read port.
// SWITCH_VOQ_FRAME_FIFO_EN adds a committed write pointer so only complete packets are released.
module switch_voq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic             wr_last,
   input  logic             rollback,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic             oversize,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr, rd;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty   = wr == rd;
   assign full    = (wr - rd) == (AW+1)'(DEPTH);
   assign rd_data = mem[rd[AW-1:0]];

   always_ff @(posedge clk)
      if (wr_en) mem[wr[AW-1:0]] <= wr_data;

`ifdef SWITCH_VOQ_FRAME_FIFO_EN
   logic [AW:0] cm;

   assign rd_valid = cm != rd;
   // full with nothing committed: the packet in flight can never fit
   assign oversize = full && (cm == rd);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr <= '0;
         cm <= '0;
      end else begin
         wr <= rollback ? cm : wr + (AW+1)'(wr_en);
         if (wr_en && wr_last) cm <= wr + (AW+1)'(1);
      end
`else
   logic unused_frame;

   assign unused_frame = ^{wr_last, rollback};
   assign rd_valid     = !empty;
   assign oversize     = 1'b0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) wr <= '0;
      else        wr <= wr + (AW+1)'(wr_en);
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                     rd <= '0;
      else if (rd_valid && rd_ready)  rd <= rd + (AW+1)'(1);

endmodule

// File: rtl/switch_ingress_voq.sv
// switch_ingress_voq: per-input-port VOQ stage steering AXIS packets into RADIX queues by one-hot tdest.
// Define SWITCH_VOQ_FRAME_FIFO_EN for store-and-forward queues with oversize packet drop.
module switch_ingress_voq
   import switch_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_ID_WIDTH   = 8,
   parameter int AXIS_USER_WIDTH = 17,
   parameter int RADIX           = 4,
   parameter int AXIS_DEST_WIDTH = RADIX,
   parameter int DEPTH           = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic                                 s_axis_tlast,
   input  logic [AXIS_ID_WIDTH-1:0]             s_axis_tid,
   input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_tdest,
   input  logic [AXIS_USER_WIDTH-1:0]           s_axis_tuser,
   output logic [RADIX*AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [RADIX*AXIS_KEEP_WIDTH-1:0]     m_axis_tkeep,
   output logic [RADIX-1:0]                     m_axis_tvalid,
   input  logic [RADIX-1:0]                     m_axis_tready,
   output logic [RADIX-1:0]                     m_axis_tlast,
   output logic [RADIX*AXIS_ID_WIDTH-1:0]       m_axis_tid,
   output logic [RADIX*AXIS_DEST_WIDTH-1:0]     m_axis_tdest,
   output logic [RADIX*AXIS_USER_WIDTH-1:0]     m_axis_tuser,
   output logic                                 status_drop_invalid,
   output logic                                 status_drop_oversize
);

   localparam int QW       = RADIX > 1 ? $clog2(RADIX) : 1;
   localparam int OFF_DEST = off_dest(AXIS_USER_WIDTH);
   localparam int OFF_ID   = off_id(AXIS_USER_WIDTH, AXIS_DEST_WIDTH);
   localparam int OFF_LAST = off_last(AXIS_USER_WIDTH, AXIS_DEST_WIDTH, AXIS_ID_WIDTH);
   localparam int OFF_KEEP = off_keep(AXIS_USER_WIDTH, AXIS_DEST_WIDTH, AXIS_ID_WIDTH);
   localparam int OFF_DATA = off_data(AXIS_USER_WIDTH, AXIS_DEST_WIDTH, AXIS_ID_WIDTH, AXIS_KEEP_WIDTH);
   localparam int EW       = entry_width(AXIS_USER_WIDTH, AXIS_DEST_WIDTH, AXIS_ID_WIDTH,
                                         AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH);

   ingress_state_e             state, state_n;
   logic [QW-1:0]              q, q_n, dec_q;
   logic [AXIS_DEST_WIDTH-1:0] dest_q;
   logic                       os_q, os_n, inv_p, os_p, ready;
   onehot_t                    dec;
   logic [RADIX-1:0]           wr_en, rollback, full, empty, oversize;
   logic [EW-1:0]              wr_data;
   logic [EW-1:0]              rd_data [RADIX];
   logic                       unused_bits;

   assign dec           = onehot_encode(32'(s_axis_tdest));
   assign dec_q         = dec.idx[QW-1:0];
   assign unused_bits   = ^{dec.idx, empty};
   assign s_axis_tready = rst_n && ready;
   // egress tdest is always the packet's first-beat tdest
   assign wr_data = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid,
                     (state == ST_IDLE) ? s_axis_tdest : dest_q, s_axis_tuser};

   always_comb begin
      state_n  = state;
      q_n      = q;
      os_n     = os_q;
      ready    = 1'b1;
      wr_en    = '0;
      rollback = '0;
      inv_p    = 1'b0;
      os_p     = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = dec.valid ? !full[dec_q] : 1'b1;
            if (s_axis_tvalid && ready) begin
               if (dec.valid) begin
                  wr_en[dec_q] = 1'b1;
                  q_n          = dec_q;
                  state_n      = s_axis_tlast ? ST_IDLE : ST_FWD;
               end else begin
                  os_n    = 1'b0;
                  inv_p   = s_axis_tlast;
                  state_n = s_axis_tlast ? ST_IDLE : ST_DROP;
               end
            end
         end
         ST_FWD: begin
            ready = !full[q];
            // packet cannot fit: discard what was written and swallow the rest
            if (s_axis_tvalid && oversize[q]) begin
               rollback[q] = 1'b1;
               os_n        = 1'b1;
               state_n     = ST_DROP;
            end else if (s_axis_tvalid && ready) begin
               wr_en[q] = 1'b1;
               state_n  = s_axis_tlast ? ST_IDLE : ST_FWD;
            end
         end
         default: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_n = ST_IDLE;
               inv_p   = !os_q;
               os_p    = os_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state                <= ST_IDLE;
         q                    <= '0;
         dest_q               <= '0;
         os_q                 <= 1'b0;
         status_drop_invalid  <= 1'b0;
         status_drop_oversize <= 1'b0;
      end else begin
         state                <= state_n;
         q                    <= q_n;
         os_q                 <= os_n;
         status_drop_invalid  <= inv_p;
         status_drop_oversize <= os_p;
         if (state == ST_IDLE && s_axis_tvalid && ready) dest_q <= s_axis_tdest;
      end

   for (genvar d = 0; d < RADIX; d++) begin : g_q
      switch_voq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[d]),
         .wr_last  (s_axis_tlast),
         .rollback (rollback[d]),
         .wr_data  (wr_data),
         .full     (full[d]),
         .empty    (empty[d]),
         .oversize (oversize[d]),
         .rd_valid (m_axis_tvalid[d]),
         .rd_ready (m_axis_tready[d]),
         .rd_data  (rd_data[d])
      );
      assign m_axis_tdata[d*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = rd_data[d][OFF_DATA +: AXIS_DATA_WIDTH];
      assign m_axis_tkeep[d*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] = rd_data[d][OFF_KEEP +: AXIS_KEEP_WIDTH];
      assign m_axis_tlast[d]                                    = rd_data[d][OFF_LAST];
      assign m_axis_tid[d*AXIS_ID_WIDTH +: AXIS_ID_WIDTH]       = rd_data[d][OFF_ID +: AXIS_ID_WIDTH];
      assign m_axis_tdest[d*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH] = rd_data[d][OFF_DEST +: AXIS_DEST_WIDTH];
      assign m_axis_tuser[d*AXIS_USER_WIDTH +: AXIS_USER_WIDTH] = rd_data[d][AXIS_USER_WIDTH-1:0];
   end

endmodule
